// File: rtl/qam16_mapper_if.sv
// Symbol-stream bundle between the QAM16 mapper (master) and its consumer/stimulus (slave).
interface qam16_mapper_if #(
  parameter int DW = 4
) ();
  logic [3:0]           code;
  logic signed [DW-1:0] i_out;
  logic signed [DW-1:0] q_out;
  logic                 sym_stb;
  logic                 run;
  logic [15:0]          sym_cnt;

  modport master (input code, output i_out, q_out, sym_stb, run, sym_cnt);
  modport slave  (output code, input i_out, q_out, sym_stb, run, sym_cnt);
endinterface

// File: rtl/qam16_mapper.sv
// QAM16 Gray mapper: samples the converter code once per symbol and emits I/Q levels with a strobe.
// Optional macro QAM16_ZERO_STUFF_EN: outputs carry the level only in the strobe cycle, zero otherwise.
module qam16_mapper #(
  parameter int SYM_CYC      = 4,
  parameter int SAMPLE_PHASE = 3,
  parameter int START_DLY    = 4,
  parameter int DW           = 4
) (
  input  logic               clk,
  input  logic               rst,
  qam16_mapper_if.master     map_o
);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  localparam logic [3:0] PH_LAST = 4'(SYM_CYC - 1);
  localparam logic [3:0] PH_SMP  = 4'(SAMPLE_PHASE);
  localparam logic [7:0] DLY     = 8'(START_DLY);

  localparam logic signed [DW-1:0] LVL_M3 = DW'(-3);
  localparam logic signed [DW-1:0] LVL_M1 = DW'(-1);
  localparam logic signed [DW-1:0] LVL_P1 = DW'(1);
  localparam logic signed [DW-1:0] LVL_P3 = DW'(3);

  // Gray order keeps adjacent amplitude levels one bit apart.
  function automatic logic signed [DW-1:0] gray_lvl(input logic [1:0] b);
    case (b)
      2'b00:   return LVL_M3;
      2'b01:   return LVL_M1;
      2'b11:   return LVL_P1;
      default: return LVL_P3;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           wait_q, wait_d;
  logic [3:0]           phase_q, phase_d;
  logic signed [DW-1:0] i_q, i_d, q_q, q_d;
  logic                 stb_q, stb_d;
  logic [15:0]          sym_cnt_q, sym_cnt_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    phase_d   = phase_q;
    i_d       = i_q;
    q_d       = q_q;
    stb_d     = 1'b0;
    sym_cnt_d = sym_cnt_q;
    case (state_q)
      S_WAIT: begin
        if (wait_q == DLY) begin
          state_d = S_RUN;
          phase_d = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_RUN: begin
        phase_d = (phase_q == PH_LAST) ? 4'd0 : phase_q + 4'd1;
        if (phase_q == PH_SMP) begin
          i_d       = gray_lvl(map_o.code[3:2]);
          q_d       = gray_lvl(map_o.code[1:0]);
          stb_d     = 1'b1;
          sym_cnt_d = sym_cnt_q + 16'd1;
        end
`ifdef QAM16_ZERO_STUFF_EN
        else begin
          i_d = '0;
          q_d = '0;
        end
`endif
      end
    endcase
  end

  // Single register stage: code at the sample edge appears right after that edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_WAIT;
      wait_q    <= '0;
      phase_q   <= '0;
      i_q       <= '0;
      q_q       <= '0;
      stb_q     <= 1'b0;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      phase_q   <= phase_d;
      i_q       <= i_d;
      q_q       <= q_d;
      stb_q     <= stb_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign map_o.i_out   = i_q;
  assign map_o.q_out   = q_q;
  assign map_o.sym_stb = stb_q;
  assign map_o.run     = (state_q == S_RUN);
  assign map_o.sym_cnt = sym_cnt_q;

endmodule
